adder_tree_var_seq: RTL and testbench
=====================================

ADDER_TREE_VAR_SEQ -- requirements
Module: adder_tree_var_seq

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of unsigned operand lanes; legal values are powers of two >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, width of each operand.
REQ-003 SHALL have parameter ACC_EXTRA, default 4, accumulator guard bits.
REQ-004 Derived: LOG = log2(NUM_IN); SW = DATA_WIDTH+LOG (sum width); AW = SW+ACC_EXTRA (output width); L = LOG+1 (latency).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 i_en  input  1  pipeline enable; 0 = stall.
REQ-008 i_mode  input  1  0 = pass-through sum, 1 = accumulate.
REQ-009 i_last  input  1  closes an accumulation group (ignored when i_mode=0).
REQ-010 i_valid  input  NUM_IN  per-lane operand valid; bit k qualifies lane k.
REQ-011 i_data_bus  input  NUM_IN*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 o_valid  output  1  o_data_bus carries a result this cycle.
REQ-013 o_data_bus  output  AW  result, unsigned, zero-extended from SW in mode 0.

Function
REQ-014 A "wave" SHALL be sampled on each rising edge with rst=1, i_en=1 and |i_valid=1; i_mode and i_last SHALL be captured with the wave and travel with it.
REQ-015 Lanes with i_valid[k]=0 SHALL contribute exactly zero; X/undefined data on invalid lanes SHALL never reach any register or output.
REQ-016 Reduction SHALL be a binary tree of LOG registered levels, each level one bit wider than the previous; no bit of the sum SHALL be lost (sum < 2^SW always).
REQ-017 The output stage SHALL be one further register; a wave sampled at edge n SHALL produce its effect at edge n+L, with i_en=1 throughout.
REQ-018 Cycles with |i_valid=0 SHALL insert a bubble: no output, no accumulator change.
REQ-019 Mode 0 wave: o_data_bus = zero-extended sum, o_valid=1 for one cycle; accumulator unchanged.
REQ-020 Mode 1 wave with last=0: accumulator += sum modulo 2^AW; o_valid=0.
REQ-021 Mode 1 wave with last=1: o_data_bus = (accumulator + sum) mod 2^AW, o_valid=1 for one cycle, accumulator cleared to 0 on the same edge.
REQ-022 Mode 0 and mode 1 waves SHALL interleave freely; an open accumulation group SHALL survive intervening mode-0 waves.
REQ-023 i_en=0 SHALL freeze every pipeline register, the accumulator, o_valid and o_data_bus; no wave is sampled; resuming continues exactly where stalled (latency extended by stall cycles).
REQ-024 When o_valid=0, o_data_bus SHALL hold its last value.
REQ-025 Back-to-back waves every cycle SHALL be accepted with no loss (throughput 1 wave/cycle).

Reset
REQ-026 rst=0 at a rising edge SHALL clear all pipeline valid bits, tagged mode/last bits, data registers, the accumulator, o_valid and o_data_bus to 0, regardless of i_en.
REQ-027 Reset mid-operation SHALL discard all in-flight waves and any open accumulation group; no output SHALL issue for them after release.
REQ-028 First wave SHALL be sampleable on the first edge with rst=1.

Verification (NUM_IN=4, DATA_WIDTH=4, ACC_EXTRA=4: SW=6, AW=10, L=3)
REQ-029 rst=0 for 2 cycles with random inputs, i_en=1 -> o_valid=0, o_data_bus=0 throughout and 1 cycle after release.
REQ-030 Mode 0, i_valid=4'b1111, all lanes 4'hF, one cycle -> exactly 3 edges later o_valid=1, o_data_bus=60 for one cycle.
REQ-031 Mode 0, i_valid=4'b0101, lanes 0..3 = 1, X, 3, X -> o_data_bus=4, no X on outputs.
REQ-032 Mode 1 waves summing 10, 20, 30 on consecutive cycles, last on third -> single o_valid pulse with 60; next group single wave sum 5 with last -> 5.
REQ-033 Mode 0 wave sum 9 followed by i_en=0 for 2 cycles -> o_valid with 9 exactly 5 edges after sampling, value intact.
REQ-034 Two mode 1 waves (sums 40, 50), then rst=0 one cycle, then mode 1 wave sum 7 with last -> only output is 7.

Source files
------------

// File: rtl/adder_tree_var_seq.sv
// Masked-lane pipelined adder tree with optional group accumulation; result LOG+1 edges after sampling.
// No ready/valid backpressure: i_en=0 freezes the whole pipeline, and the latency grows by one for each stalled cycle.
module adder_tree_var_seq #(
  parameter  int NUM_IN     = 4,
  parameter  int DATA_WIDTH = 4,
  parameter  int ACC_EXTRA  = 4,
  localparam int LOG        = $clog2(NUM_IN),
  localparam int SW         = DATA_WIDTH + LOG,
  localparam int AW         = SW + ACC_EXTRA
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic                           i_mode,
  input  logic                           i_last,
  input  logic [NUM_IN-1:0]              i_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0]   i_data_bus,
  output logic                           o_valid,
  output logic [AW-1:0]                  o_data_bus
);

  // Heap-ordered tree: node i has children 2i+1 and 2i+2, lane k lives at leaf NUM_IN-1+k, root is node 0.
  logic [SW-1:0] r_node [2*NUM_IN-1];
  logic [LOG:0]  r_vld;
  logic [LOG:0]  r_mode;
  logic [LOG:0]  r_last;
  logic [AW-1:0] r_acc;
  logic          r_o_valid;
  logic [AW-1:0] r_o_data;

  logic [SW-1:0] w_lane [NUM_IN];
  logic          w_wave;
  logic [AW-1:0] w_root;
  logic [AW-1:0] w_acc_sum;

  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      w_lane[k] = i_valid[k] ? SW'(i_data_bus[k*DATA_WIDTH +: DATA_WIDTH]) : '0;
    end
  end

  assign w_wave    = |i_valid;
  assign w_root    = AW'(r_node[0]);
  assign w_acc_sum = r_acc + w_root;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2*NUM_IN-1; i++) begin
        r_node[i] <= '0;
      end
      r_vld     <= '0;
      r_mode    <= '0;
      r_last    <= '0;
      r_acc     <= '0;
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
    end else if (i_en) begin
      for (int k = 0; k < NUM_IN; k++) begin
        r_node[NUM_IN-1+k] <= w_lane[k];
      end
      for (int i = 0; i < NUM_IN-1; i++) begin
        r_node[i] <= r_node[2*i+1] + r_node[2*i+2];
      end
      r_vld  <= {r_vld[LOG-1:0], w_wave};
      r_mode <= {r_mode[LOG-1:0], i_mode};
      r_last <= {r_last[LOG-1:0], i_last};

      r_o_valid <= 1'b0;
      if (r_vld[LOG]) begin
        if (!r_mode[LOG]) begin
          r_o_valid <= 1'b1;
          r_o_data  <= w_root;
        end else if (!r_last[LOG]) begin
          r_acc <= w_acc_sum;
        end else begin
          r_o_valid <= 1'b1;
          r_o_data  <= w_acc_sum;
          r_acc     <= '0;
        end
      end
    end
  end

  assign o_valid    = r_o_valid;
  assign o_data_bus = r_o_data;

endmodule

// File: tb/tb_adder_tree_var_seq.sv
// Directed and random bench for adder_tree_var_seq against a timed-queue reference model.
module tb_adder_tree_var_seq;
  localparam int NI = 4;
  localparam int DW = 4;
  localparam int AE = 4;
  localparam int L  = 3;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             i_en;
  logic             i_mode;
  logic             i_last;
  logic [NI-1:0]    i_valid;
  logic [NI*DW-1:0] i_data_bus;
  logic             o_valid;
  logic [AW-1:0]    o_data_bus;

  adder_tree_var_seq #(.NUM_IN(NI), .DATA_WIDTH(DW), .ACC_EXTRA(AE)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_mode(i_mode), .i_last(i_last),
    .i_valid(i_valid), .i_data_bus(i_data_bus),
    .o_valid(o_valid), .o_data_bus(o_data_bus)
  );

  typedef struct {
    int sum;
    bit mode;
    bit last;
    int left;
  } wave_t;

  wave_t q[$];
  int    outs[$];
  int    acc;
  int    exp_v;
  int    exp_d;
  int    n_pass = 0;
  int    n_chk  = 0;

  function automatic int lane_sum();
    int s = 0;
    for (int k = 0; k < NI; k++) begin
      if (i_valid[k]) s += int'(i_data_bus[k*DW +: DW]);
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive(input bit r, input bit en, input bit mode, input bit last,
                       input logic [NI-1:0] vld, input logic [NI*DW-1:0] dat);
    rst = r; i_en = en; i_mode = mode; i_last = last; i_valid = vld; i_data_bus = dat;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  // Model: every accepted wave carries a countdown of L enabled edges; when it expires, it is retired.
  task automatic tick();
    wave_t w;
    bit    new_out;
    @(posedge clk);
    new_out = 0;
    if (!rst) begin
      q.delete();
      acc = 0; exp_v = 0; exp_d = 0;
    end else if (i_en) begin
      exp_v = 0;
      foreach (q[j]) q[j].left--;
      while (q.size() > 0 && q[0].left == 0) begin
        w = q.pop_front();
        if (!w.mode) begin
          exp_v = 1; exp_d = w.sum;
        end else if (!w.last) begin
          acc = (acc + w.sum) % (1 << AW);
        end else begin
          exp_v = 1; exp_d = (acc + w.sum) % (1 << AW); acc = 0;
        end
      end
      if (|i_valid) q.push_back('{lane_sum(), i_mode, i_last, L});
      new_out = 1;
    end
    #1;
    check("o_valid", AW'(o_valid), AW'(exp_v));
    check("o_data_bus", o_data_bus, AW'(exp_d));
    if (new_out && o_valid === 1'b1) outs.push_back(int'(o_data_bus));
  endtask

  initial begin
    logic [NI*DW-1:0] xdat;
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    acc = 0; exp_v = 0; exp_d = 0;

    // Reset with random inputs for 2 cycles, then one idle cycle after release.
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), NI'($urandom), (NI*DW)'($urandom));
      tick();
    end
    idle(); tick();

    // Full-scale mode-0 wave.
    outs.delete();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 16'hFFFF); tick();
    idle(); repeat (4) tick();
    check("max_cnt", AW'(outs.size()), 10'd1);
    if (outs.size() > 0) check("max_val", AW'(outs[0]), 10'd60);

    // Invalid lanes carry X.
    outs.delete();
    xdat = 16'hx3x1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, xdat); tick();
    idle(); repeat (4) tick();
    check("xmask_unknown", AW'($isunknown(o_data_bus)), 10'd0);
    check("xmask_cnt", AW'(outs.size()), 10'd1);
    if (outs.size() > 0) check("xmask_val", AW'(outs[0]), 10'd4);

    // Accumulation groups 10+20+30 and then a single-wave group of 5.
    outs.delete();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0011, 16'h0055); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 16'h5555); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 16'h55AA); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 16'h0005); tick();
    idle(); repeat (5) tick();
    check("acc_cnt", AW'(outs.size()), 10'd2);
    if (outs.size() > 1) begin
      check("acc_grp1", AW'(outs[0]), 10'd60);
      check("acc_grp2", AW'(outs[1]), 10'd5);
    end

    // Stall for two cycles behind a mode-0 wave of 9.
    outs.delete();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 16'h0045); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0); repeat (2) tick();
    idle(); tick(); tick();
    check("stall_early", AW'(outs.size()), 10'd0);
    tick();
    check("stall_cnt", AW'(outs.size()), 10'd1);
    if (outs.size() > 0) check("stall_val", AW'(outs[0]), 10'd9);
    repeat (2) tick();

    // Reset discards an open group (40, 50) that is still in flight.
    outs.delete();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 16'hAAAA); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 16'hFFAA); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0); tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 16'h0007); tick();
    idle(); repeat (5) tick();
    check("rst_grp_cnt", AW'(outs.size()), 10'd1);
    if (outs.size() > 0) check("rst_grp_val", AW'(outs[0]), 10'd7);

    // Random traffic: stalls, bubbles, mixed modes, occasional reset.
    for (int c = 0; c < 500; c++) begin
      drive(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom), 1'($urandom_range(0, 2) == 0),
            NI'($urandom), (NI*DW)'($urandom));
      tick();
    end
    idle(); repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
